ts_sync_detector: RTL and testbench
===================================

Name: ts_sync_detector

Overview:
- Per-channel MPEG2-TS packet aligner.
- Receives a byte stream from one input channel, hunts for the sync byte, verifies the 188-byte packet period, declares lock, and flywheels through occasional corrupted sync bytes.
- Drives the per-channel sync bit that the sync selection multiplexer consumes. Four instances feed its sync[3:0] bus, one per channel.

Parameters:
- PKT_LEN, 188, packet length in bytes (≥ 4).
- SYNC_BYTE, 8'h47, sync byte value.
- LOCK_CNT, 3, consecutive correct sync bytes at packet boundaries required to declare lock (≥ 1; first sync found in HUNT counts as 1).
- UNLOCK_CNT, 3, consecutive missed sync bytes while locked that cause loss of lock (≥ 1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- byte_in  input  8  channel data byte
- byte_valid  input  1  byte_in valid this cycle; no backpressure
- data_out  output  8  byte_in delayed 1 cycle
- valid_out  output  1  byte_valid delayed 1 cycle
- sync_out  output  1  one-cycle pulse aligned with the data_out byte at packet start while locked
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse aligned with the data_out byte at an expected boundary whose value ≠ SYNC_BYTE while locked

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is HUNT.
  - pos = 0, good_cnt = 0, miss_cnt = 0.
- Byte acceptance: a byte is accepted only on cycles with byte_valid = 1. With byte_valid = 0, pos, counters and state hold, and valid_out, sync_out and sync_err are 0 the next cycle.
- Latency: every output is registered, 1 cycle after byte acceptance. data_out is updated only on valid bytes.
- pos tracks the byte position within the packet, 0..PKT_LEN-1, and wraps from PKT_LEN-1 to 0. A boundary byte is an accepted byte with pos = 0.
- HUNT:
  - Accepted byte == SYNC_BYTE: set good_cnt = 1 and pos = 1.
    - If LOCK_CNT = 1, go to LOCKED and pulse sync_out.
    - Otherwise go to VERIFY.
  - Any other byte: stay in HUNT.
- VERIFY:
  - Non-boundary byte: pos++.
  - Boundary byte == SYNC_BYTE: good_cnt++ and pos = 1.
    - If good_cnt reaches LOCK_CNT: go to LOCKED, assert locked, pulse sync_out. Both appear on the same output cycle.
  - Boundary byte ≠ SYNC_BYTE: go to HUNT, clear good_cnt, set pos = 0. The mismatching byte is not re-evaluated as a new sync candidate.
- LOCKED:
  - Every boundary byte pulses sync_out, whether or not it matches (flywheel).
  - Match: miss_cnt = 0.
  - Mismatch:
    - Pulse sync_err and increment miss_cnt.
    - If miss_cnt reaches UNLOCK_CNT: go to HUNT, deassert locked, clear both counters, set pos = 0. sync_out still pulses for this byte; locked is 0 on that same output cycle.
- Counter widths: pos is clog2(PKT_LEN) bits. good_cnt and miss_cnt saturate at their targets and never wrap.
- Reset mid-packet: on the next cycle all state returns to reset values and any in-flight output pulse is suppressed.
- Channel behaviour:
  - Gaps in byte_valid have no effect on alignment.
  - A continuous 0x47 stream in HUNT locks only if the period holds.

Optional Feature:
- Macro: TS_SYNC_ERR_CNT_EN.
- When defined:
  - Adds output port err_count [15:0], counting sync_err pulses.
  - Saturates at 16'hFFFF and is cleared by rst.
  - Holds its value across loss and reacquisition of lock.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Clean stream, defaults: 4 packets each starting 0x47, filler 0x00, byte_valid = 1 → locked rises on data_out of byte 376 (3rd sync). sync_out pulses at bytes 376 and 564. sync_err never pulses.
- False sync in HUNT: 0x47 at byte 10, no 0x47 at byte 198, real packets start at 300 → VERIFY aborts at byte 198 back to HUNT. Lock is achieved at byte 676 with no premature locked.
- Flywheel: after lock, corrupt 2 consecutive sync bytes to 0x00, 3rd intact → sync_out and sync_err both pulse on the 2 corrupted boundaries. locked stays 1. miss_cnt resets on the 3rd boundary.
- Loss of lock: after lock, corrupt 3 consecutive sync bytes → 3 sync_err pulses. locked falls on the same output cycle as the 3rd pulse. Reacquisition needs 3 fresh good syncs.
- Gapped valid: locked stream with byte_valid low 1 cycle in every 4 → sync_out remains every 188 valid bytes. valid_out mirrors the gaps. sync_out, sync_err and valid_out are 0 during gaps.
- Reset mid-packet: assert rst at pos 90 while locked → next cycle locked = 0 and all outputs 0. With TS_SYNC_ERR_CNT_EN defined, err_count = 0.

Source files
------------

// File: rtl/ts_sync_detector_if.sv
// Byte-stream bundle between a TS channel source and its packet aligner.
// err_count exists only when TS_SYNC_ERR_CNT_EN is defined.
interface ts_sync_detector_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        sync_out;
    logic        locked;
    logic        sync_err;
`ifdef TS_SYNC_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    modport master (
        output byte_in, byte_valid,
        input  data_out, valid_out, sync_out, locked, sync_err
`ifdef TS_SYNC_ERR_CNT_EN
        , input err_count
`endif
    );

    modport slave (
        input  byte_in, byte_valid,
        output data_out, valid_out, sync_out, locked, sync_err
`ifdef TS_SYNC_ERR_CNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/ts_sync_detector.sv
// Per-channel MPEG2-TS aligner: hunt for the sync byte, verify the packet period, lock and flywheel.
// Optional macro TS_SYNC_ERR_CNT_EN adds a saturating 16-bit sync_err counter (err_count).
module ts_sync_detector #(
    parameter int         PKT_LEN    = 188,
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 3
) (
    input  logic               clk,
    input  logic               rst,
    ts_sync_detector_if.slave  chan
);
    localparam int PW = $clog2(PKT_LEN);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    localparam logic [PW-1:0] POS_LAST = PW'(PKT_LEN - 1);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_TGT = MW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pos, pos_nxt;
    logic [GW-1:0] good_cnt, good_nxt;
    logic [MW-1:0] miss_cnt, miss_nxt;
    logic          sync_nxt, err_nxt;

    logic          is_sync, boundary;
    logic [PW-1:0] pos_inc;

    logic [7:0]    data_p1;
    logic          valid_p1, sync_p1, err_p1, locked_p1;

    assign is_sync  = (chan.byte_in == SYNC_BYTE);
    assign boundary = (pos == '0);
    assign pos_inc  = (pos == POS_LAST) ? '0 : pos + PW'(1);

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        good_nxt  = good_cnt;
        miss_nxt  = miss_cnt;
        sync_nxt  = 1'b0;
        err_nxt   = 1'b0;

        if (chan.byte_valid) begin
            unique case (state)
                HUNT: begin
                    if (is_sync) begin
                        good_nxt = GW'(1);
                        pos_nxt  = PW'(1);
                        if (LOCK_CNT == 1) begin
                            state_nxt = LOCKED;
                            sync_nxt  = 1'b1;
                            miss_nxt  = '0;
                        end else begin
                            state_nxt = VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    if (!boundary) begin
                        pos_nxt = pos_inc;
                    end else if (is_sync) begin
                        good_nxt = good_cnt + GW'(1);
                        pos_nxt  = PW'(1);
                        if (good_cnt + GW'(1) >= GOOD_TGT) begin
                            state_nxt = LOCKED;
                            sync_nxt  = 1'b1;
                            miss_nxt  = '0;
                        end
                    end else begin
                        // The failed candidate is dropped; hunting resumes with the next byte.
                        state_nxt = HUNT;
                        good_nxt  = '0;
                        pos_nxt   = '0;
                    end
                end

                LOCKED: begin
                    pos_nxt = pos_inc;
                    if (boundary) begin
                        // Flywheel: the expected boundary is flagged whether or not it matched.
                        sync_nxt = 1'b1;
                        if (is_sync) begin
                            miss_nxt = '0;
                        end else begin
                            err_nxt  = 1'b1;
                            miss_nxt = miss_cnt + MW'(1);
                            if (miss_cnt + MW'(1) >= MISS_TGT) begin
                                state_nxt = HUNT;
                                good_nxt  = '0;
                                miss_nxt  = '0;
                                pos_nxt   = '0;
                            end
                        end
                    end
                end

                default: begin
                    state_nxt = HUNT;
                    good_nxt  = '0;
                    miss_nxt  = '0;
                    pos_nxt   = '0;
                end
            endcase
        end
    end

    // Stage p1: state update and registered outputs, one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            pos       <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            data_p1   <= '0;
            valid_p1  <= 1'b0;
            sync_p1   <= 1'b0;
            err_p1    <= 1'b0;
            locked_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos       <= pos_nxt;
            good_cnt  <= good_nxt;
            miss_cnt  <= miss_nxt;
            if (chan.byte_valid) begin
                data_p1 <= chan.byte_in;
            end
            valid_p1  <= chan.byte_valid;
            sync_p1   <= sync_nxt;
            err_p1    <= err_nxt;
            locked_p1 <= (state_nxt == LOCKED);
        end
    end

    assign chan.data_out  = data_p1;
    assign chan.valid_out = valid_p1;
    assign chan.sync_out  = sync_p1;
    assign chan.sync_err  = err_p1;
    assign chan.locked    = locked_p1;

`ifdef TS_SYNC_ERR_CNT_EN
    logic [15:0] err_cnt_p1;

    // Survives loss and reacquisition of lock; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_p1 <= '0;
        end else if (err_nxt && (err_cnt_p1 != 16'hFFFF)) begin
            err_cnt_p1 <= err_cnt_p1 + 16'd1;
        end
    end

    assign chan.err_count = err_cnt_p1;
`else
    // Error counter not built.
`endif

endmodule

// File: tb/tb_ts_sync_detector.sv
// Bench for ts_sync_detector: scenario table with hand-derived event positions, a few
// hand sequences, and randomized streams checked cycle by cycle against a reference model.
module tb_ts_sync_detector;
    localparam int         PKT      = 188;
    localparam int         LOCK_N   = 3;
    localparam int         UNLOCK_N = 3;
    localparam logic [7:0] SB       = 8'h47;

    logic clk = 1'b0;
    logic rst;

    ts_sync_detector_if chan();

    ts_sync_detector #(
        .PKT_LEN   (PKT),
        .SYNC_BYTE (SB),
        .LOCK_CNT  (LOCK_N),
        .UNLOCK_CNT(UNLOCK_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .chan(chan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Reference model: alignment anchored to the index of the first accepted sync byte.
    int         m_n, m_anchor, m_good, m_miss, m_errcnt;
    bit         m_lck, m_valid, m_sync, m_err;
    logic [7:0] m_data;

    // Observed event statistics, indexed by valid output byte.
    int obs_cnt, lock_idx, unlock_idx, n_sync, n_err, n_rise;
    bit prev_lck;

    typedef struct {
        string name;
        int    npkt;
        int    cmask;
        int    gap;
        int    lock_at;
        int    syncs;
        int    errs;
        int    unlock_at;
        int    rises;
        int    fin_lock;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s (cycle %0d): got %0d (0x%h), expected %0d (0x%h)",
                      name, cyc, $signed(act), act, $signed(exp), exp);
    endtask

    task automatic model_reset();
        m_n = 0; m_anchor = -1; m_good = 0; m_miss = 0; m_errcnt = 0;
        m_lck = 0; m_valid = 0; m_sync = 0; m_err = 0; m_data = 8'h00;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        m_valid = v;
        m_sync  = 0;
        m_err   = 0;
        if (!v) return;
        m_data = b;
        if (m_anchor < 0) begin
            if (b == SB) begin
                m_anchor = m_n;
                m_good   = 1;
                if (m_good >= LOCK_N) begin m_lck = 1; m_sync = 1; m_miss = 0; end
            end
        end else if (((m_n - m_anchor) % PKT) == 0) begin
            if (!m_lck) begin
                if (b == SB) begin
                    m_good++;
                    if (m_good >= LOCK_N) begin m_lck = 1; m_sync = 1; m_miss = 0; end
                end else begin
                    m_anchor = -1; m_good = 0;
                end
            end else begin
                m_sync = 1;
                if (b == SB) m_miss = 0;
                else begin
                    m_err = 1;
                    if (m_errcnt < 65535) m_errcnt++;
                    m_miss++;
                    if (m_miss >= UNLOCK_N) begin
                        m_lck = 0; m_anchor = -1; m_good = 0; m_miss = 0;
                    end
                end
            end
        end
        m_n++;
    endtask

    task automatic stats_clear();
        obs_cnt = 0; lock_idx = -1; unlock_idx = -1; n_sync = 0; n_err = 0; n_rise = 0;
        prev_lck = 0;
    endtask

    task automatic tick(input bit r, input bit v, input logic [7:0] b);
        rst = r;
        chan.byte_valid = v;
        chan.byte_in    = b;
        @(posedge clk);
        cyc++;
        if (r) model_reset();
        else   model_step(v, b);
        @(negedge clk);
        check("outputs{data,valid,sync,err,locked}",
              32'({chan.data_out, chan.valid_out, chan.sync_out, chan.sync_err, chan.locked}),
              32'({m_data, m_valid, m_sync, m_err, m_lck}));
`ifdef TS_SYNC_ERR_CNT_EN
        check("err_count", 32'(chan.err_count), 32'(m_errcnt));
`endif
        if (chan.valid_out === 1'b1) begin
            if (chan.locked === 1'b1 && lock_idx < 0) lock_idx = obs_cnt;
            if (chan.sync_out === 1'b1) n_sync++;
            if (chan.sync_err === 1'b1) n_err++;
            if (prev_lck && chan.locked !== 1'b1 && unlock_idx < 0) unlock_idx = obs_cnt;
            obs_cnt++;
        end
        if (!prev_lck && chan.locked === 1'b1) n_rise++;
        prev_lck = (chan.locked === 1'b1);
    endtask

    task automatic do_reset();
        tick(1, 0, 8'h00);
        tick(1, 0, 8'h00);
        stats_clear();
    endtask

    // Packets start with SB (or 0x00 where cmask marks them corrupt), filler 0x00.
    task automatic send_pkts(input int npkt, input int cmask, input int gap);
        int k;
        logic [7:0] b;
        k = 0;
        for (int p = 0; p < npkt; p++) begin
            for (int i = 0; i < PKT; i++) begin
                if (i == 0) b = (((cmask >> p) & 1) != 0) ? 8'h00 : SB;
                else        b = 8'h00;
                if (gap > 0) begin
                    k++;
                    if ((k % gap) == 0) tick(0, 0, 8'hA5);
                end
                tick(0, 1, b);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        chan.byte_valid = 1'b0;
        chan.byte_in    = 8'h00;
        model_reset();

        //        name           npkt cmask gap lock syncs errs unlock rises final
        vt[0] = '{"clean",          4, 'h00, 0,  376,  2,   0,   -1,   1,    1};
        vt[1] = '{"flywheel",       7, 'h18, 0,  376,  5,   2,   -1,   1,    1};
        vt[2] = '{"loss_relock",    9, 'h38, 0,  376,  5,   3,  940,   2,    1};
        vt[3] = '{"loss_only",      6, 'h38, 0,  376,  4,   3,  940,   1,    0};
        vt[4] = '{"gapped",         4, 'h00, 4,  376,  2,   0,   -1,   1,    1};
        vt[5] = '{"verify_abort",   5, 'h02, 0,  752,  1,   0,   -1,   1,    1};

        // Reset state
        do_reset();
        check("reset_outputs",
              32'({chan.data_out, chan.valid_out, chan.sync_out, chan.sync_err, chan.locked}), 32'd0);

        for (int t = 0; t < $size(vt); t++) begin
            do_reset();
            send_pkts(vt[t].npkt, vt[t].cmask, vt[t].gap);
            check($sformatf("%s.lock_at", vt[t].name),   32'(lock_idx),   32'(vt[t].lock_at));
            check($sformatf("%s.syncs", vt[t].name),     32'(n_sync),     32'(vt[t].syncs));
            check($sformatf("%s.errs", vt[t].name),      32'(n_err),      32'(vt[t].errs));
            check($sformatf("%s.unlock_at", vt[t].name), 32'(unlock_idx), 32'(vt[t].unlock_at));
            check($sformatf("%s.rises", vt[t].name),     32'(n_rise),     32'(vt[t].rises));
            check($sformatf("%s.final_lock", vt[t].name), 32'(chan.locked), 32'(vt[t].fin_lock));
        end

        // False sync at byte 10, real packets from byte 300.
        do_reset();
        for (int i = 0; i < 300; i++) tick(0, 1, (i == 10) ? SB : 8'h00);
        send_pkts(3, 0, 0);
        check("false_sync.lock_at", 32'(lock_idx), 32'd676);
        check("false_sync.syncs",   32'(n_sync),   32'd1);
        check("false_sync.rises",   32'(n_rise),   32'd1);

        // Reset at pos 90 while locked, after one corrupted boundary.
        do_reset();
        send_pkts(3, 0, 0);
        tick(0, 1, 8'h00);
        for (int i = 1; i < 90; i++) tick(0, 1, 8'h00);
        check("rst_mid.pre_locked", 32'(chan.locked), 32'd1);
        check("rst_mid.pre_errs",   32'(n_err),       32'd1);
`ifdef TS_SYNC_ERR_CNT_EN
        check("rst_mid.pre_err_count", 32'(chan.err_count), 32'd1);
`endif
        tick(1, 1, SB);
        check("rst_mid.outputs",
              32'({chan.data_out, chan.valid_out, chan.sync_out, chan.sync_err, chan.locked}), 32'd0);
`ifdef TS_SYNC_ERR_CNT_EN
        check("rst_mid.err_count", 32'(chan.err_count), 32'd0);
`endif

        // Randomized streams: corrupt syncs, length slips, gaps, rare resets.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int p = 0; p < 15; p++) begin
                int len;
                len = PKT;
                if ($urandom_range(0, 11) == 0) len = PKT - 1 + int'($urandom_range(0, 2));
                for (int i = 0; i < len; i++) begin
                    logic [7:0] b;
                    if (i == 0) b = ($urandom_range(0, 6) == 0) ? 8'($urandom) : SB;
                    else        b = ($urandom_range(0, 299) == 0) ? SB : 8'($urandom_range(0, 70));
                    while ($urandom_range(0, 4) == 0) tick(0, 0, 8'($urandom));
                    if ($urandom_range(0, 2999) == 0) tick(1, 1, b);
                    else                              tick(0, 1, b);
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
